// File: rtl/vga_pkg.sv
// Shared definitions for the VGA page path: page encodings, colours and bus widths.
package vga_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned RGB_W   = 24;

  typedef enum logic [1:0] {
    PAGE_WELCOME = 2'd0,
    PAGE_MENU    = 2'd1,
    PAGE_PLAY    = 2'd2
  } page_e;

  localparam logic [RGB_W-1:0] BG_RGB   = 24'h000000;
  localparam logic [RGB_W-1:0] MENU_RGB = 24'h202080;
  localparam logic [RGB_W-1:0] PLAY_RGB = 24'h208020;

endpackage

// File: rtl/vga_pic_window.sv
// Picture window: tests the pixel position against a rectangle, forms the ROM
// address and aligns ROM data with the pixel stream over two register stages.
module vga_pic_window
  import vga_pkg::*;
#(
  parameter int unsigned      X0        = 170,
  parameter int unsigned      Y0        = 100,
  parameter int unsigned      W         = 300,
  parameter int unsigned      H         = 100,
  parameter logic [RGB_W-1:0] RST_COLOR = BG_RGB
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic               en,
  input  logic [RGB_W-1:0]   fill,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [RGB_W-1:0]   rom_data,
  output logic [RGB_W-1:0]   pix_data
);

  logic [COORD_W-1:0] dx;
  logic [COORD_W-1:0] dy;
  logic               in_win;
  logic [ADDR_W-1:0]  addr;
  logic               win_d1;
  logic [RGB_W-1:0]   fill_d1;

  // Modular subtraction makes positions left of / above the window wrap to
  // large values, so a single unsigned compare per axis covers both edges.
  always_comb begin
    dx     = pos_x - COORD_W'(X0);
    dy     = pos_y - COORD_W'(Y0);
    in_win = (dx < COORD_W'(W)) && (dy < COORD_W'(H));
    addr   = in_win ? (ADDR_W'(dy) * ADDR_W'(W) + ADDR_W'(dx)) : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the two stages stay one cycle apart.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr <= '0;
      win_d1   <= 1'b0;
      fill_d1  <= RST_COLOR;
      pix_data <= RST_COLOR;
    end else begin
      rom_addr <= addr;
      win_d1   <= in_win && en;
      fill_d1  <= fill;
      pix_data <= win_d1 ? rom_data : fill_d1;
    end
  end

endmodule

// File: rtl/vga_page_sequencer.sv
// Page sequencer: WELCOME -> MENU -> PLAY, with page changes applied only at
// frame_start; owns the picture ROM port through vga_pic_window.
module vga_page_sequencer
  import vga_pkg::*;
#(
  parameter int unsigned      PIC_X0         = 170,
  parameter int unsigned      PIC_Y0         = 100,
  parameter int unsigned      PIC_W          = 300,
  parameter int unsigned      PIC_H          = 100,
  parameter int unsigned      WELCOME_FRAMES = 180,
  parameter logic [RGB_W-1:0] BG_COLOR       = vga_pkg::BG_RGB,
  parameter logic [RGB_W-1:0] MENU_COLOR     = vga_pkg::MENU_RGB,
  parameter logic [RGB_W-1:0] PLAY_COLOR     = vga_pkg::PLAY_RGB
) (
  input  logic               vga_clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic               frame_start,
  input  logic               key_any,
  input  logic [1:0]         mode_req,
  input  logic               mode_req_vld,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [RGB_W-1:0]   rom_data,
  output logic [RGB_W-1:0]   pix_data,
  output logic [1:0]         page_id,
  output logic               page_chg
);

  localparam int unsigned      CNT_W    = (WELCOME_FRAMES > 1) ? $clog2(WELCOME_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WELCOME_FRAMES - 1);

  page_e            state_q, state_d;
  page_e            pend_page_q, pend_page_d;
  logic             pend_vld_q, pend_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             apply;
  logic             timeout;
  logic [RGB_W-1:0] fill;

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state_q     <= PAGE_WELCOME;
      pend_vld_q  <= 1'b0;
      pend_page_q <= PAGE_WELCOME;
      cnt_q       <= '0;
      page_chg    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_vld_q  <= pend_vld_d;
      pend_page_q <= pend_page_d;
      cnt_q       <= cnt_d;
      page_chg    <= apply;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d     = PAGE_WELCOME;
    pend_vld_d  = pend_vld_q;
    pend_page_d = pend_page_q;
    cnt_d       = cnt_q;
    fill        = BG_COLOR;

    case (state_q)
      PAGE_WELCOME: state_d = PAGE_WELCOME;
      PAGE_MENU:    begin state_d = PAGE_MENU; fill = MENU_COLOR; end
      PAGE_PLAY:    begin state_d = PAGE_PLAY; fill = PLAY_COLOR; end
      default:      state_d = PAGE_WELCOME;
    endcase

    apply = frame_start && pend_vld_q && (pend_page_q != state_q);
    if (apply) state_d = pend_page_q;

    // A request applied on the timeout frame suppresses the auto-advance, so
    // MENU can never be queued a second time behind it.
    cnt_inc = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CNT_W'(1);
    timeout = frame_start && (state_q == PAGE_WELCOME) && (cnt_inc == CNT_LAST) && !apply;

    if (state_d != PAGE_WELCOME) cnt_d = '0;
    else if (frame_start)        cnt_d = cnt_inc;

    if (frame_start) pend_vld_d = 1'b0;
    if (timeout || (key_any && state_q == PAGE_WELCOME)) begin
      pend_vld_d  = 1'b1;
      pend_page_d = PAGE_MENU;
    end
    if (mode_req_vld && (mode_req == 2'd1 || mode_req == 2'd2)) begin
      pend_vld_d  = 1'b1;
      pend_page_d = page_e'(mode_req);
    end
  end

  assign page_id = state_q;

  vga_pic_window #(
    .X0       (PIC_X0),
    .Y0       (PIC_Y0),
    .W        (PIC_W),
    .H        (PIC_H),
    .RST_COLOR(BG_COLOR)
  ) u_pic_window (
    .clk     (vga_clk),
    .rst     (rst),
    .pos_x   (pos_x),
    .pos_y   (pos_y),
    .en      (state_q == PAGE_WELCOME),
    .fill    (fill),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .pix_data(pix_data)
  );

endmodule

// File: tb/tb_vga_page_sequencer.sv
// Directed bench for vga_page_sequencer with WELCOME_FRAMES shortened to 4.
module tb_vga_page_sequencer;

  localparam logic [23:0] BG   = 24'h000000;
  localparam logic [23:0] MENU = 24'h202080;
  localparam logic [23:0] PLAY = 24'h208020;

  logic        vga_clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  pos_x = '0;
  logic [9:0]  pos_y = '0;
  logic        frame_start = 1'b0;
  logic        key_any = 1'b0;
  logic [1:0]  mode_req = '0;
  logic        mode_req_vld = 1'b0;
  logic [15:0] rom_addr;
  logic [23:0] rom_data;
  logic [23:0] pix_data;
  logic [1:0]  page_id;
  logic        page_chg;

  int checks = 0;
  int errors = 0;

  always #5 vga_clk = ~vga_clk;

  // Picture ROM stand-in: data tags the address so alignment is visible.
  assign rom_data = {8'hA5, rom_addr};

  vga_page_sequencer #(.WELCOME_FRAMES(4)) dut (
    .vga_clk     (vga_clk),
    .rst         (rst),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .frame_start (frame_start),
    .key_any     (key_any),
    .mode_req    (mode_req),
    .mode_req_vld(mode_req_vld),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .pix_data    (pix_data),
    .page_id     (page_id),
    .page_chg    (page_chg)
  );

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic set_pos(input int x, input int y);
    pos_x = 10'(x);
    pos_y = 10'(y);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (page_id !== 2'd0) begin errors++; $display("FAIL reset_page got %0d exp 0", page_id); end
    checks++; if (page_chg !== 1'b0) begin errors++; $display("FAIL reset_chg got %0b exp 0", page_chg); end
    checks++; if (rom_addr !== 16'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", rom_addr); end
    checks++; if (pix_data !== BG) begin errors++; $display("FAIL reset_pix got %h exp %h", pix_data, BG); end
  endtask

  task automatic test_window();
    set_pos(170, 100); step();
    checks++; if (rom_addr !== 16'd0) begin errors++; $display("FAIL win_corner_addr got %0d exp 0", rom_addr); end
    set_pos(469, 199); step();
    checks++; if (rom_addr !== 16'd29999) begin errors++; $display("FAIL win_last_addr got %0d exp 29999", rom_addr); end
    checks++; if (pix_data !== 24'hA50000) begin errors++; $display("FAIL win_corner_pix got %h exp a50000", pix_data); end
    set_pos(169, 100); step();
    checks++; if (rom_addr !== 16'd0) begin errors++; $display("FAIL win_left_addr got %0d exp 0", rom_addr); end
    checks++; if (pix_data !== 24'hA5752F) begin errors++; $display("FAIL win_last_pix got %h exp a5752f", pix_data); end
    set_pos(470, 150); step();
    checks++; if (rom_addr !== 16'd0) begin errors++; $display("FAIL win_right_addr got %0d exp 0", rom_addr); end
    checks++; if (pix_data !== BG) begin errors++; $display("FAIL win_left_pix got %h exp %h", pix_data, BG); end
    set_pos(300, 150); step();
    checks++; if (rom_addr !== 16'd15130) begin errors++; $display("FAIL win_mid_addr got %0d exp 15130", rom_addr); end
    checks++; if (pix_data !== BG) begin errors++; $display("FAIL win_right_pix got %h exp %h", pix_data, BG); end
    set_pos(300, 99); step();
    checks++; if (rom_addr !== 16'd0) begin errors++; $display("FAIL win_above_addr got %0d exp 0", rom_addr); end
    checks++; if (pix_data !== 24'hA53B1A) begin errors++; $display("FAIL win_mid_pix got %h exp a53b1a", pix_data); end
    step();
    checks++; if (pix_data !== BG) begin errors++; $display("FAIL win_above_pix got %h exp %h", pix_data, BG); end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int f = 1; f <= 3; f++) begin
      frame();
      checks++; if (page_id !== 2'd0 || page_chg !== 1'b0) begin
        errors++; $display("FAIL timeout_hold frame %0d got page %0d chg %0b exp 0 0", f, page_id, page_chg);
      end
    end
    frame();
    checks++; if (page_id !== 2'd1 || page_chg !== 1'b1) begin
      errors++; $display("FAIL timeout_adv got page %0d chg %0b exp 1 1", page_id, page_chg);
    end
    step();
    checks++; if (page_chg !== 1'b0) begin errors++; $display("FAIL timeout_pulse got chg %0b exp 0", page_chg); end
  endtask

  task automatic test_key();
    do_reset();
    set_pos(0, 0); step();
    key_any = 1'b1; step(); key_any = 1'b0;
    step();
    checks++; if (page_id !== 2'd0) begin errors++; $display("FAIL key_wait got %0d exp 0", page_id); end
    frame();
    checks++; if (page_id !== 2'd1 || page_chg !== 1'b1) begin
      errors++; $display("FAIL key_apply got page %0d chg %0b exp 1 1", page_id, page_chg);
    end
    set_pos(1, 0); step();
    checks++; if (pix_data !== BG || page_chg !== 1'b0) begin
      errors++; $display("FAIL key_pix1 got %h chg %0b exp %h 0", pix_data, page_chg, BG);
    end
    set_pos(2, 0); step();
    checks++; if (pix_data !== MENU) begin errors++; $display("FAIL key_menu_pix got %h exp %h", pix_data, MENU); end
  endtask

  task automatic test_last_wins();
    do_reset();
    mode_req = 2'd2; mode_req_vld = 1'b1; key_any = 1'b1; step();
    key_any = 1'b0; mode_req = 2'd1; step();
    mode_req_vld = 1'b0; step();
    frame();
    checks++; if (page_id !== 2'd1 || page_chg !== 1'b1) begin
      errors++; $display("FAIL last_wins got page %0d chg %0b exp 1 1", page_id, page_chg);
    end
  endtask

  task automatic test_precedence();
    do_reset();
    mode_req = 2'd2; mode_req_vld = 1'b1; key_any = 1'b1; step();
    mode_req_vld = 1'b0; key_any = 1'b0; step();
    frame();
    checks++; if (page_id !== 2'd2 || page_chg !== 1'b1) begin
      errors++; $display("FAIL mode_over_key got page %0d chg %0b exp 2 1", page_id, page_chg);
    end
    step();
    mode_req = 2'd3; mode_req_vld = 1'b1; step();
    mode_req = 2'd0; step();
    mode_req_vld = 1'b0;
    frame();
    checks++; if (page_id !== 2'd2 || page_chg !== 1'b0) begin
      errors++; $display("FAIL ignore_req got page %0d chg %0b exp 2 0", page_id, page_chg);
    end
  endtask

  task automatic test_play();
    set_pos(200, 120); step();
    checks++; if (rom_addr !== 16'd6030) begin errors++; $display("FAIL play_addr got %0d exp 6030", rom_addr); end
    step();
    checks++; if (pix_data !== PLAY) begin errors++; $display("FAIL play_pix got %h exp %h", pix_data, PLAY); end
    mode_req = 2'd2; mode_req_vld = 1'b1; step();
    mode_req_vld = 1'b0;
    frame();
    checks++; if (page_id !== 2'd2 || page_chg !== 1'b0) begin
      errors++; $display("FAIL same_page got page %0d chg %0b exp 2 0", page_id, page_chg);
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; step(); rst = 1'b0;
    checks++; if (page_id !== 2'd0 || page_chg !== 1'b0 || rom_addr !== 16'd0 || pix_data !== BG) begin
      errors++; $display("FAIL midrst got page %0d chg %0b addr %0d pix %h exp 0 0 0 %h",
                         page_id, page_chg, rom_addr, pix_data, BG);
    end
    step();
    checks++; if (rom_addr !== 16'd6030 || pix_data !== BG) begin
      errors++; $display("FAIL midrst_refill got addr %0d pix %h exp 6030 %h", rom_addr, pix_data, BG);
    end
    step();
    checks++; if (pix_data !== 24'hA5178E) begin errors++; $display("FAIL midrst_rom_pix got %h exp a5178e", pix_data); end
    for (int f = 1; f <= 3; f++) begin
      frame();
      checks++; if (page_id !== 2'd0) begin errors++; $display("FAIL midrst_cnt frame %0d got %0d exp 0", f, page_id); end
    end
    frame();
    checks++; if (page_id !== 2'd1 || page_chg !== 1'b1) begin
      errors++; $display("FAIL midrst_adv got page %0d chg %0b exp 1 1", page_id, page_chg);
    end
  endtask

  task automatic test_timeout_collide();
    do_reset();
    frame();
    frame();
    mode_req = 2'd2; mode_req_vld = 1'b1; step();
    mode_req_vld = 1'b0;
    frame();
    checks++; if (page_id !== 2'd2 || page_chg !== 1'b1) begin
      errors++; $display("FAIL collide_apply got page %0d chg %0b exp 2 1", page_id, page_chg);
    end
    step();
    frame();
    checks++; if (page_id !== 2'd2 || page_chg !== 1'b0) begin
      errors++; $display("FAIL collide_no_menu got page %0d chg %0b exp 2 0", page_id, page_chg);
    end
  endtask

  initial begin
    test_reset();
    test_window();
    test_timeout();
    test_key();
    test_last_wins();
    test_precedence();
    test_play();
    test_reset_mid();
    test_timeout_collide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
